// File: rtl/edge_phase_meter_pkg.sv
// Shared types and default sizing for the edge-to-edge phase meter.
`timescale 1ns/1ps
package edge_phase_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CNT_W_DEF    = 16;
  localparam int LOG2_AVG_DEF = 4;
  localparam int ACC_W        = CNT_W_DEF + LOG2_AVG_DEF;
  localparam int N_AVG        = 1 << LOG2_AVG_DEF;

endpackage

// File: rtl/edge_phase_meter_sync_rise_detect.sv
// Multi-flop synchronizer for one asynchronous input, followed by a history
// flop that turns a synchronized 0->1 transition into a single-cycle pulse.
`timescale 1ns/1ps
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/edge_phase_meter.sv
// Measures ref->meas rising-edge delay in clk cycles and reports the floor
// of the mean over 2^LOG2_AVG samples on a valid/ready output.
`timescale 1ns/1ps
module edge_phase_meter
  import edge_phase_meter_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int          LOG2_AVG    = LOG2_AVG_DEF,
  parameter int unsigned TIMEOUT     = 32'hFFFF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             meas_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_delay,
  output logic             timeout_err,
  output logic             busy
);

  localparam int               SUM_W  = CNT_W + LOG2_AVG;
  localparam int               N_SAMP = 1 << LOG2_AVG;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [SUM_W-1:0]    acc;
  logic [LOG2_AVG:0]   n_samp;
  logic                ref_rise, meas_rise;
  logic                rec_en, to_hit, clr_all, load_cnt, inc_cnt;
  logic [CNT_W-1:0]    rec_val;
  logic [CNT_W-1:0]    delay_now;
  logic [SUM_W-1:0]    acc_sum;
  logic                last_samp;
  logic                accept;

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ref_in),
    .rise     (ref_rise)
  );

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_meas_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (meas_in),
    .rise     (meas_rise)
  );

  // cnt holds 0 in the first COUNT cycle, so the delay seen now is cnt+1
  assign delay_now = cnt + CNT_W'(1);
  assign acc_sum   = acc + SUM_W'(rec_val);
  assign last_samp = (n_samp == (LOG2_AVG+1)'(N_SAMP - 1));
  assign accept    = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rec_en     = 1'b0;
    rec_val    = '0;
    to_hit     = 1'b0;
    clr_all    = 1'b0;
    load_cnt   = 1'b0;
    inc_cnt    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !out_valid) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          clr_all    = 1'b1;
          state_next = IDLE;
        end else if (ref_rise) begin
          if (meas_rise) begin
            rec_en = 1'b1;
          end else begin
            load_cnt   = 1'b1;
            state_next = COUNT;
          end
        end
      end
      COUNT: begin
        // Reaching the limit wins over a coincident meas edge
        if (!enable) begin
          clr_all    = 1'b1;
          state_next = IDLE;
        end else if (delay_now >= TO_LIM) begin
          to_hit     = 1'b1;
          state_next = ARMED;
        end else if (meas_rise) begin
          rec_en     = 1'b1;
          rec_val    = delay_now;
          state_next = ARMED;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      HOLD: begin
        if (accept) state_next = enable ? ARMED : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rec_en && last_samp) state_next = HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      n_samp      <= '0;
      out_valid   <= 1'b0;
      out_delay   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (clr_all) begin
        cnt    <= '0;
        acc    <= '0;
        n_samp <= '0;
      end else begin
        if (load_cnt)     cnt <= '0;
        else if (inc_cnt) cnt <= cnt + CNT_W'(1);
        if (rec_en) begin
          if (last_samp) begin
            out_delay <= acc_sum[SUM_W-1:LOG2_AVG];
            out_valid <= 1'b1;
            acc       <= '0;
            n_samp    <= '0;
          end else begin
            acc    <= acc_sum;
            n_samp <= n_samp + (LOG2_AVG+1)'(1);
          end
        end
      end
      if (state == HOLD && accept) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_phase_meter.sv
// Scoreboard bench for edge_phase_meter: directed ref/meas waveforms with
// hand-computed mean delays, checked by a monitor on each accepted result.
`timescale 1ns/1ps
module tb_edge_phase_meter;
  import edge_phase_meter_pkg::*;

  localparam int CW = 16;
  localparam int LA = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          ref_in = 1'b0;
  logic          meas_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          timeout_err;
  logic          busy;
  logic [CW-1:0] out_delay;

  int checks = 0;
  int errors = 0;
  int to_count = 0;
  int results = 0;
  int exp_q[$];

  always #2 clk = ~clk;

  edge_phase_meter #(
    .CNT_W       (CW),
    .LOG2_AVG    (LA),
    .TIMEOUT     (100),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ref_in      (ref_in),
    .meas_in     (meas_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_delay   (out_delay),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One period: ref high for the first half, meas the same shape shifted by delay
  task automatic apply_stimulus(input int delay, input bit meas_on, input int period);
    for (int c = 0; c < period; c++) begin
      ref_in  = (c < period / 2);
      meas_in = meas_on && (c >= delay) && (c < delay + period / 2);
      tick(1);
    end
    ref_in  = 1'b0;
    meas_in = 1'b0;
  endtask

  task automatic run_batch(input int delay);
    for (int i = 0; i < N_AVG; i++) apply_stimulus(delay, 1'b1, 100);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (timeout_err) to_count++;
      if (out_valid && out_ready) begin
        results++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got %0d, expected no result", out_delay);
        end else begin
          check_output("result", int'(out_delay), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [ACC_W-1:0] alt_sum;
    int bad;

    tick(3);
    check_output("rst_valid", int'(out_valid), 0);
    check_output("rst_delay", int'(out_delay), 0);
    check_output("rst_timeout", int'(timeout_err), 0);
    check_output("rst_busy", int'(busy), 0);

    rst_n = 1'b1;
    tick(2);
    enable    = 1'b1;
    out_ready = 1'b1;
    tick(5);
    check_output("armed_busy", int'(busy), 1);

    exp_q.push_back(10);
    run_batch(10);
    tick(20);
    check_output("const_results", results, 1);

    alt_sum = '0;
    for (int i = 0; i < N_AVG; i++) alt_sum += ACC_W'((i % 2) ? 6 : 5);
    exp_q.push_back(int'(alt_sum >> LA));
    for (int i = 0; i < N_AVG; i++) apply_stimulus((i % 2) ? 6 : 5, 1'b1, 100);
    tick(20);

    exp_q.push_back(0);
    run_batch(0);
    tick(20);
    check_output("simul_results", results, 3);
    check_output("no_timeouts", to_count, 0);

    repeat (3) apply_stimulus(0, 1'b0, 200);
    tick(20);
    check_output("timeout_pulses", to_count, 3);
    check_output("timeout_no_result", results, 3);

    exp_q.push_back(3);
    run_batch(3);
    tick(20);
    check_output("after_timeout_results", results, 4);

    out_ready = 1'b0;
    exp_q.push_back(7);
    run_batch(7);
    for (int i = 0; i < 200 && !out_valid; i++) tick(1);
    check_output("bp_valid", int'(out_valid), 1);
    bad = 0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 100; c++) begin
        ref_in  = (c < 50);
        meas_in = (c >= 20) && (c < 70);
        tick(1);
        if (!out_valid || out_delay != 16'd7 || !busy) bad++;
      end
    end
    ref_in  = 1'b0;
    meas_in = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick(1);
      if (!out_valid || out_delay != 16'd7 || !busy) bad++;
    end
    check_output("bp_stable_bad_cycles", bad, 0);
    check_output("bp_no_timeouts", to_count, 3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check_output("accept_drop", int'(out_valid), 0);
    check_output("accept_rearmed", int'(busy), 1);
    out_ready = 1'b1;
    exp_q.push_back(12);
    run_batch(12);
    tick(20);
    check_output("resume_results", results, 6);

    repeat (7) apply_stimulus(30, 1'b1, 100);
    enable = 1'b0;
    tick(10);
    check_output("abort_idle", int'(busy), 0);
    enable = 1'b1;
    tick(5);
    exp_q.push_back(15);
    run_batch(15);
    tick(20);
    check_output("abort_results", results, 7);

    ref_in = 1'b1;
    tick(10);
    check_output("count_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_delay", int'(out_delay), 0);
    check_output("midrst_valid", int'(out_valid), 0);
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_timeout", int'(timeout_err), 0);
    ref_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    check_output("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
